// File: rtl/tank_batch_ctrl.sv
// Mixing-tank batch controller: fill, mix, drain, repeat while run is high.
// Define TANK_SENSOR_CHECK_EN to fault on h_level high while l_level is low.
module tank_batch_ctrl #(
   parameter int N_PUMPS       = 2,
   parameter int CNT_W         = 16,
   parameter int MIX_CYCLES    = 7000,
   parameter int FILL_TIMEOUT  = 50000,
   parameter int DRAIN_TIMEOUT = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               l_level,
   input  logic               h_level,
   input  logic               run,
   input  logic               stop,
   input  logic               fault_clr,
   output logic [N_PUMPS-1:0] pump,
   output logic               mixer,
   output logic               valve,
   output logic [2:0]         state,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [15:0]        batch_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_MIX   = 3'd2,
      S_DRAIN = 3'd3,
      S_FAULT = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       code_q, code_d;
   logic [15:0]      batch_q, batch_d;
   logic             full, empty, implaus;

   assign full  = l_level & h_level;
   assign empty = !l_level & !h_level;

`ifdef TANK_SENSOR_CHECK_EN
   assign implaus = h_level & !l_level;
`else
   assign implaus = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      batch_d = batch_q;
      if (state_q != S_FAULT && implaus) begin
         state_d = S_FAULT;
         code_d  = 2'd3;
         cnt_d   = '0;
      end else if (state_q != S_FAULT && stop) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_d = full ? S_MIX : S_FILL;
                  cnt_d   = full ? MIX_LAST : '0;
               end
            end
            S_FILL: begin
               if (full) begin
                  state_d = S_MIX;
                  cnt_d   = MIX_LAST;
               end else if (cnt_q == FILL_LAST) begin
                  state_d = S_FAULT;
                  code_d  = 2'd1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_MIX: begin
               // losing the high mark means a top-up; the mix restarts
               if (!h_level) begin
                  state_d = S_FILL;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  batch_d = batch_q + 16'd1;
                  state_d = run ? S_FILL : S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DRAIN_LAST) begin
                  state_d = S_FAULT;
                  code_d  = 2'd2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_FAULT: begin
               if (fault_clr) begin
                  state_d = S_IDLE;
                  code_d  = 2'd0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               code_d  = 2'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         code_q  <= 2'd0;
         batch_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         batch_q <= batch_d;
      end
   end

   always_comb begin
      pump  = '0;
      mixer = 1'b0;
      valve = 1'b0;
      case (state_q)
         S_FILL:  pump  = '1;
         S_MIX:   mixer = 1'b1;
         S_DRAIN: valve = 1'b1;
         default: ;
      endcase
   end

   assign state       = state_q;
   assign fault       = (state_q == S_FAULT);
   assign fault_code  = code_q;
   assign batch_count = batch_q;

endmodule
